// File: rtl/risc16_tile_if.sv
// rtl/risc16_tile_if.sv - Wishbone instruction-memory and I/O bus bundle for risc16_tile
interface risc16_tile_if #(parameter int ADDRESS = 23);
    localparam int AW = ADDRESS - 2;

    logic          mem_cyc_o, mem_stb_o, mem_we_o;
    logic          mem_ack_i, mem_rty_i, mem_err_i;
    logic [2:0]    mem_cti_o;
    logic [1:0]    mem_bte_o;
    logic [AW-1:0] mem_adr_o;
    logic [3:0]    mem_sel_o;
    logic [31:0]   mem_dat_o;
    logic [3:0]    mem_sel_i;
    logic [31:0]   mem_dat_i;

    logic          io_cyc_o, io_stb_o, io_we_o;
    logic          io_ack_i, io_rty_i, io_err_i;
    logic [2:0]    io_cti_o;
    logic [1:0]    io_bte_o;
    logic [AW-1:0] io_adr_o;
    logic [1:0]    io_sel_o;
    logic [15:0]   io_dat_o;
    logic [1:0]    io_sel_i;
    logic [15:0]   io_dat_i;

    modport master (
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_cti_o, mem_bte_o, mem_adr_o, mem_sel_o, mem_dat_o,
        input  mem_ack_i, mem_rty_i, mem_err_i, mem_sel_i, mem_dat_i,
        output io_cyc_o, io_stb_o, io_we_o, io_cti_o, io_bte_o, io_adr_o, io_sel_o, io_dat_o,
        input  io_ack_i, io_rty_i, io_err_i, io_sel_i, io_dat_i
    );

    modport slave (
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_cti_o, mem_bte_o, mem_adr_o, mem_sel_o, mem_dat_o,
        output mem_ack_i, mem_rty_i, mem_err_i, mem_sel_i, mem_dat_i,
        input  io_cyc_o, io_stb_o, io_we_o, io_cti_o, io_bte_o, io_adr_o, io_sel_o, io_dat_o,
        output io_ack_i, io_rty_i, io_err_i, io_sel_i, io_dat_i
    );
endinterface

// File: rtl/risc16_tile.sv
// rtl/risc16_tile.sv - multi-cycle 16-bit RISC tile with one-line burst-filled I-cache and 16-bit I/O master
module risc16_tile #(parameter int ADDRESS = 23) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cpu_clk_i,
    input  logic          cache_rst_i,
    risc16_tile_if.master bus
);
    localparam int AW = ADDRESS - 2;

    typedef enum logic [2:0] {S_FETCH, S_FILL, S_EXEC, S_IO, S_HALT} state_e;

    state_e        state_q, state_d;
    logic [15:0]   pc_q, pc_d, ir_q, ir_d;
    logic [15:0]   rf_q [16];
    logic [31:0]   line_q [4];
    logic [12:0]   tag_q, tag_d;
    logic          valid_q, valid_d, bad_q, bad_d;
    logic [1:0]    beat_q, beat_d;
    logic          mem_cyc_q, mem_cyc_d;
    logic [2:0]    mem_cti_q, mem_cti_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic          io_cyc_q, io_cyc_d, io_we_q, io_we_d;
    logic [AW-1:0] io_adr_q, io_adr_d;
    logic [15:0]   io_dat_q, io_dat_d;
    logic          rf_we, line_we;
    logic [15:0]   rf_wd;

    logic [3:0]  op, rd, ra, rb;
    logic [15:0] va, vb, vd, imm8s, imm4s, ea, fetch_word;
    logic [31:0] line_word;
    logic        hit, io_done, unused_ok;

    assign op         = ir_q[15:12];
    assign rd         = ir_q[11:8];
    assign ra         = ir_q[7:4];
    assign rb         = ir_q[3:0];
    assign va         = rf_q[ra];
    assign vb         = rf_q[rb];
    assign vd         = rf_q[rd];
    assign imm8s      = {{8{ir_q[7]}}, ir_q[7:0]};
    assign imm4s      = {{12{ir_q[3]}}, ir_q[3:0]};
    assign ea         = va + imm4s;
    assign line_word  = line_q[pc_q[2:1]];
    assign fetch_word = pc_q[0] ? line_word[31:16] : line_word[15:0];
    assign hit        = valid_q && (tag_q == pc_q[15:3]);
    assign io_done    = bus.io_ack_i | bus.io_err_i | bus.io_rty_i;
    assign unused_ok  = ^{cpu_clk_i, bus.mem_sel_i, bus.io_sel_i};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        bad_d     = bad_q;
        beat_d    = beat_q;
        mem_cyc_d = mem_cyc_q;
        mem_cti_d = mem_cti_q;
        mem_adr_d = mem_adr_q;
        io_cyc_d  = io_cyc_q;
        io_we_d   = io_we_q;
        io_adr_d  = io_adr_q;
        io_dat_d  = io_dat_q;
        rf_we     = 1'b0;
        rf_wd     = 16'h0;
        line_we   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (hit) begin
                    ir_d    = fetch_word;
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_FILL;
                    mem_cyc_d = 1'b1;
                    mem_cti_d = 3'b010;
                    mem_adr_d = AW'({pc_q[15:3], 2'b00});
                    beat_d    = 2'd0;
                    valid_d   = 1'b0;
                    bad_d     = 1'b0;
                    tag_d     = pc_q[15:3];
                end
            end
            S_FILL: begin
                // An invalidate landing mid-burst poisons the line without cutting the burst short.
                if (cache_rst_i) bad_d = 1'b1;
                if (bus.mem_err_i || bus.mem_rty_i) begin
                    mem_cyc_d = 1'b0;
                    mem_cti_d = 3'b000;
                    state_d   = S_FETCH;
                end else if (bus.mem_ack_i) begin
                    line_we = 1'b1;
                    if (beat_q == 2'd3) begin
                        mem_cyc_d = 1'b0;
                        mem_cti_d = 3'b000;
                        valid_d   = !bad_q && !cache_rst_i;
                        state_d   = S_FETCH;
                    end else begin
                        beat_d    = beat_q + 2'd1;
                        mem_adr_d = mem_adr_q + AW'(1);
                        mem_cti_d = (beat_q == 2'd2) ? 3'b111 : 3'b010;
                    end
                end
            end
            S_EXEC: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_FETCH;
                unique case (op)
                    4'h0: begin rf_we = 1'b1; rf_wd = va + vb; end
                    4'h1: begin rf_we = 1'b1; rf_wd = va - vb; end
                    4'h2: begin rf_we = 1'b1; rf_wd = va & vb; end
                    4'h3: begin rf_we = 1'b1; rf_wd = va | vb; end
                    4'h4: begin rf_we = 1'b1; rf_wd = va ^ vb; end
                    4'h6: begin rf_we = 1'b1; rf_wd = va << vb[3:0]; end
                    4'h7: begin rf_we = 1'b1; rf_wd = va >> vb[3:0]; end
                    4'h8: begin rf_we = 1'b1; rf_wd = imm8s; end
                    4'h9: begin rf_we = 1'b1; rf_wd = {ir_q[7:0], vd[7:0]}; end
                    4'hA: begin rf_we = 1'b1; rf_wd = va + imm4s; end
                    4'hB: if (vd == 16'h0) pc_d = pc_q + 16'd1 + imm8s;
                    4'hC: pc_d = va;
                    4'hD, 4'hE: begin
                        pc_d     = pc_q;
                        state_d  = S_IO;
                        io_cyc_d = 1'b1;
                        io_we_d  = (op == 4'hE);
                        // Top three ea bits land at the top of the I/O space so 0xC000 hits the flush decode.
                        io_adr_d = AW'(ea[12:0]) | (AW'(ea[15:13]) << (AW - 3));
                        if (op == 4'hE) io_dat_d = vd;
                    end
                    4'hF: begin pc_d = pc_q; state_d = S_HALT; end
                    default: ;
                endcase
            end
            S_IO: begin
                if (io_done) begin
                    io_cyc_d = 1'b0;
                    io_we_d  = 1'b0;
                    pc_d     = pc_q + 16'd1;
                    state_d  = S_FETCH;
                    if (op == 4'hD) begin
                        rf_we = 1'b1;
                        rf_wd = (bus.io_ack_i && !bus.io_err_i && !bus.io_rty_i) ? bus.io_dat_i : 16'h0;
                    end
                end
            end
            default: ;
        endcase

        if (cache_rst_i) valid_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            bad_q     <= 1'b0;
            beat_q    <= '0;
            mem_cyc_q <= 1'b0;
            mem_cti_q <= '0;
            mem_adr_q <= '0;
            io_cyc_q  <= 1'b0;
            io_we_q   <= 1'b0;
            io_adr_q  <= '0;
            io_dat_q  <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
            for (int i = 0; i < 4; i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            bad_q     <= bad_d;
            beat_q    <= beat_d;
            mem_cyc_q <= mem_cyc_d;
            mem_cti_q <= mem_cti_d;
            mem_adr_q <= mem_adr_d;
            io_cyc_q  <= io_cyc_d;
            io_we_q   <= io_we_d;
            io_adr_q  <= io_adr_d;
            io_dat_q  <= io_dat_d;
            if (rf_we && rd != 4'd0) rf_q[rd] <= rf_wd;
            if (line_we) line_q[beat_q] <= bus.mem_dat_i;
        end
    end

    assign bus.mem_cyc_o = mem_cyc_q;
    assign bus.mem_stb_o = mem_cyc_q;
    assign bus.mem_we_o  = 1'b0;
    assign bus.mem_cti_o = mem_cti_q;
    assign bus.mem_bte_o = 2'b00;
    assign bus.mem_adr_o = mem_adr_q;
    assign bus.mem_sel_o = 4'hF;
    assign bus.mem_dat_o = 32'h0;
    assign bus.io_cyc_o  = io_cyc_q;
    assign bus.io_stb_o  = io_cyc_q;
    assign bus.io_we_o   = io_we_q;
    assign bus.io_cti_o  = 3'b000;
    assign bus.io_bte_o  = 2'b00;
    assign bus.io_adr_o  = io_adr_q;
    assign bus.io_sel_o  = 2'b11;
    assign bus.io_dat_o  = io_dat_q;
endmodule

// File: tb/tb_risc16_tile.sv
// tb/tb_risc16_tile.sv - self-checking bench for risc16_tile against an instruction-level reference model
module tb_risc16_tile;
    localparam int ADDRESS = 23;
    localparam int FLUSH_ADR = 32'h180000;

    typedef struct {
        bit          we;
        int          adr;
        logic [15:0] dat;
    } io_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cache_rst = 1'b0;
    always #5 clk = ~clk;

    risc16_tile_if #(.ADDRESS(ADDRESS)) bus ();

    risc16_tile #(.ADDRESS(ADDRESS)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cpu_clk_i  (clk),
        .cache_rst_i(cache_rst),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prog [256];
    io_rec_t exp_q[$];
    io_rec_t obs_q[$];
    int fill_q[$];
    int beat_adr_q[$];
    int beat_cti_q[$];
    int mem_wait = 0, io_wait = 0, io_err_adr = -1, mem_fault = 0;
    int viol = 0, io_viol = 0;

    function automatic logic [15:0] enc(int op, int d, int a, int b);
        return 16'((op << 12) | (d << 8) | (a << 4) | (b & 15));
    endfunction

    function automatic logic [15:0] enc8(int op, int d, int imm);
        return 16'((op << 12) | (d << 8) | (imm & 255));
    endfunction

    function automatic logic [15:0] io_rd(int a);
        if (a == 2) return 16'h1234;
        return 16'((a * 40503) ^ 23100);
    endfunction

    function automatic int io_map(int ea);
        return ((ea >> 13) & 7) * 32'h40000 + (ea & 32'h1FFF);
    endfunction

    // Architectural interpreter: produces the ordered list of I/O accesses a correct tile must issue.
    function automatic void model_run();
        int r [16];
        int pc, ins, op, d, a, b, i8, i4, adr;
        io_rec_t rec;
        exp_q.delete();
        foreach (r[i]) r[i] = 0;
        pc = 0;
        for (int s = 0; s < 5000; s++) begin
            ins = int'(prog[pc & 255]);
            op = (ins >> 12) & 15; d = (ins >> 8) & 15; a = (ins >> 4) & 15; b = ins & 15;
            i8 = ((ins & 255) >= 128) ? (ins & 255) - 256 : (ins & 255);
            i4 = (b >= 8) ? b - 16 : b;
            pc = pc + 1;
            case (op)
                0:  r[d] = r[a] + r[b];
                1:  r[d] = r[a] - r[b];
                2:  r[d] = r[a] & r[b];
                3:  r[d] = r[a] | r[b];
                4:  r[d] = r[a] ^ r[b];
                6:  r[d] = r[a] << (r[b] & 15);
                7:  r[d] = r[a] >> (r[b] & 15);
                8:  r[d] = i8;
                9:  r[d] = ((ins & 255) << 8) | (r[d] & 255);
                10: r[d] = r[a] + i4;
                11: if (r[d] == 0) pc = pc + i8;
                12: pc = r[a];
                13, 14: begin
                    adr = io_map((r[a] + i4) & 32'hFFFF);
                    rec.we = (op == 14); rec.adr = adr; rec.dat = (op == 14) ? 16'(r[d]) : 16'h0;
                    exp_q.push_back(rec);
                    if (op == 13) r[d] = (adr == io_err_adr) ? 0 : int'(io_rd(adr));
                end
                15: return;
                default: ;
            endcase
            r[d] = r[d] & 32'hFFFF;
            r[0] = 0;
            pc = pc & 32'hFFFF;
        end
    endfunction

    int m_cnt = 0, m_beat = 0, m_start = 0;
    bit m_prev = 1'b0, m_last = 1'b0;
    always @(negedge clk) begin
        bus.mem_ack_i = 1'b0; bus.mem_err_i = 1'b0; bus.mem_rty_i = 1'b0;
        if (rst) begin
            m_prev = 1'b0; m_last = 1'b0; m_cnt = 0;
        end else begin
            if (m_last && bus.mem_cyc_o) viol++;
            m_last = 1'b0;
            if (bus.mem_cyc_o && !m_prev) begin
                fill_q.push_back(int'(bus.mem_adr_o));
                m_start = int'(bus.mem_adr_o); m_beat = 0; m_cnt = 0;
            end
            if (bus.mem_cyc_o) begin
                if (bus.mem_stb_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_sel_o !== 4'hF ||
                    bus.mem_bte_o !== 2'b00 || int'(bus.mem_adr_o) != m_start + m_beat ||
                    bus.mem_cti_o !== ((m_beat == 3) ? 3'b111 : 3'b010)) viol++;
                if (m_cnt < mem_wait) m_cnt++;
                else begin
                    m_cnt = 0;
                    if (mem_fault == 1) begin bus.mem_err_i = 1'b1; mem_fault = 0; end
                    else if (mem_fault == 2) begin bus.mem_rty_i = 1'b1; mem_fault = 0; end
                    else begin
                        bus.mem_ack_i = 1'b1;
                        bus.mem_dat_i = {prog[(2 * int'(bus.mem_adr_o) + 1) & 255], prog[(2 * int'(bus.mem_adr_o)) & 255]};
                        beat_adr_q.push_back(int'(bus.mem_adr_o));
                        beat_cti_q.push_back(int'(bus.mem_cti_o));
                        m_last = (m_beat == 3);
                        m_beat++;
                    end
                end
            end
            m_prev = bus.mem_cyc_o;
        end
    end

    int i_cnt = 0;
    bit i_last = 1'b0;
    always @(negedge clk) begin
        io_rec_t rec;
        bus.io_ack_i = 1'b0; bus.io_err_i = 1'b0; bus.io_rty_i = 1'b0;
        cache_rst = 1'b0;
        if (rst) begin
            i_cnt = 0; i_last = 1'b0;
        end else begin
            if (i_last && bus.io_cyc_o) io_viol++;
            i_last = 1'b0;
            if (bus.io_cyc_o) begin
                if (bus.io_stb_o !== 1'b1 || bus.io_sel_o !== 2'b11 || bus.io_cti_o !== 3'b000 ||
                    bus.io_bte_o !== 2'b00) io_viol++;
                if (i_cnt < io_wait) i_cnt++;
                else begin
                    i_cnt = 0; i_last = 1'b1;
                    rec.we = bus.io_we_o; rec.adr = int'(bus.io_adr_o);
                    rec.dat = bus.io_we_o ? bus.io_dat_o : 16'h0;
                    obs_q.push_back(rec);
                    if (rec.adr == io_err_adr) bus.io_err_i = 1'b1;
                    else begin
                        bus.io_ack_i = 1'b1;
                        bus.io_dat_i = io_rd(rec.adr);
                        if (rec.we && rec.adr == FLUSH_ADR) cache_rst = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_prog();
        model_run();
        @(posedge clk); #2 rst = 1'b1;
        obs_q.delete(); fill_q.delete(); beat_adr_q.delete(); beat_cti_q.delete();
        viol = 0; io_viol = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 8000 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (60) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        foreach (prog[i]) prog[i] = 16'hF000;
        rst = 1'b1; mem_wait = 0; io_wait = 0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.io_cyc_o, bus.io_stb_o, bus.io_we_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 000000", {bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.io_cyc_o, bus.io_stb_o, bus.io_we_o});
        end
        n_cmp++;
        if (bus.mem_adr_o !== '0 || bus.io_adr_o !== '0 || bus.mem_cti_o !== 3'b000) begin
            n_bad++; $display("FAIL reset_adr got mem=%h io=%h cti=%b want 0", bus.mem_adr_o, bus.io_adr_o, bus.mem_cti_o);
        end
        n_cmp++;
        if (bus.io_dat_o !== 16'h0 || bus.mem_dat_o !== 32'h0 || bus.mem_sel_o !== 4'hF || bus.io_sel_o !== 2'b11) begin
            n_bad++; $display("FAIL reset_data got io_dat=%h mem_dat=%h sel=%h/%b", bus.io_dat_o, bus.mem_dat_o, bus.mem_sel_o, bus.io_sel_o);
        end
        beat_adr_q.delete(); beat_cti_q.delete(); fill_q.delete(); viol = 0;
        rst = 1'b0;
        for (int c = 0; c < 50 && beat_adr_q.size() < 4; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (beat_adr_q.size() <= i) begin
                n_bad++; $display("FAIL first_burst beat %0d missing got %0d beats want 4", i, beat_adr_q.size());
            end else if (beat_adr_q[i] != i || beat_cti_q[i] != ((i == 3) ? 7 : 2)) begin
                n_bad++; $display("FAIL first_burst beat %0d got adr=%0d cti=%0d want adr=%0d cti=%0d", i, beat_adr_q[i], beat_cti_q[i], i, (i == 3) ? 7 : 2);
            end
        end
        n_cmp++;
        if (viol != 0) begin n_bad++; $display("FAIL first_burst_protocol got %0d violations want 0", viol); end
        repeat (100) @(posedge clk);
        #2;
        n_cmp++;
        if (fill_q.size() != 1 || bus.mem_cyc_o !== 1'b0) begin
            n_bad++; $display("FAIL halt_at_0 got %0d bursts cyc=%b want 1 burst cyc=0", fill_q.size(), bus.mem_cyc_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        mem_wait = 0;
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (bus.mem_cyc_o === 1'b1) break;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_cyc_o !== 1'b0 || bus.mem_stb_o !== 1'b0 || bus.mem_adr_o !== '0 || bus.mem_cti_o !== 3'b000) begin
            n_bad++; $display("FAIL reset_mid_burst got cyc=%b stb=%b adr=%h cti=%b want 0", bus.mem_cyc_o, bus.mem_stb_o, bus.mem_adr_o, bus.mem_cti_o);
        end
    endtask

    task automatic test_program();
        int n4;
        bit saw8;
        int busy;
        foreach (prog[i]) prog[i] = 16'hF000;
        prog[0]  = enc8(8, 1, 5);
        prog[1]  = enc8(8, 2, 3);
        prog[2]  = enc(0, 3, 1, 2);
        prog[3]  = enc(14, 3, 0, 1);
        prog[4]  = enc8(8, 4, 8'hC0);
        prog[5]  = enc8(8, 5, 8);
        prog[6]  = enc(6, 4, 4, 5);
        prog[7]  = enc(5, 0, 0, 0);
        prog[8]  = enc(14, 0, 4, 0);
        prog[9]  = enc(13, 6, 0, 2);
        prog[10] = enc(14, 6, 0, 3);
        prog[11] = enc8(11, 0, 8);
        prog[20] = enc(14, 1, 0, 4);
        prog[21] = 16'hF000;
        mem_wait = 1; io_wait = 2; io_err_adr = -1;
        run_prog();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL prog io_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].we !== exp_q[i].we || obs_q[i].adr != exp_q[i].adr || (exp_q[i].we && obs_q[i].dat !== exp_q[i].dat)) begin
                n_bad++; $display("FAIL prog io[%0d] got we=%0b adr=%h dat=%h want we=%0b adr=%h dat=%h", i, obs_q[i].we, obs_q[i].adr, obs_q[i].dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
            end
        end
        n_cmp++;
        if (obs_q.size() < 4 || obs_q[0].adr != 1 || obs_q[0].dat !== 16'h0008 || obs_q[0].we !== 1'b1 ||
            obs_q[1].adr != FLUSH_ADR || obs_q[3].dat !== 16'h1234) begin
            n_bad++; $display("FAIL prog_fixed_values got %0d accesses want st 1=0008, flush 180000, st 0x1234", obs_q.size());
        end
        n4 = 0; saw8 = 1'b0;
        foreach (fill_q[i]) begin
            if (fill_q[i] == 4) n4++;
            if (fill_q[i] == 8) saw8 = 1'b1;
        end
        n_cmp++;
        if (n4 != 2) begin n_bad++; $display("FAIL flush_refill got %0d bursts at adr 4 want 2", n4); end
        n_cmp++;
        if (!saw8) begin n_bad++; $display("FAIL bz_new_line got no burst at adr 8 want one"); end
        n_cmp++;
        if (viol != 0 || io_viol != 0) begin
            n_bad++; $display("FAIL prog_protocol got mem=%0d io=%0d violations want 0", viol, io_viol);
        end
        busy = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (bus.mem_cyc_o || bus.io_cyc_o) busy++;
        end
        n_cmp++;
        if (busy != 0) begin n_bad++; $display("FAIL halt_quiet got %0d busy cycles want 0", busy); end
    endtask

    task automatic test_io_error();
        foreach (prog[i]) prog[i] = 16'hF000;
        prog[0]  = enc8(8, 7, 8'h55);
        prog[1]  = enc(13, 7, 0, 5);
        prog[2]  = enc(14, 7, 0, 6);
        prog[3]  = enc8(8, 9, 12);
        prog[4]  = enc(12, 0, 9, 0);
        prog[12] = enc8(8, 8, 1);
        prog[13] = enc(14, 8, 0, 7);
        mem_wait = 0; io_wait = 1; io_err_adr = 5;
        run_prog();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL io_err io_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].we !== exp_q[i].we || obs_q[i].adr != exp_q[i].adr || (exp_q[i].we && obs_q[i].dat !== exp_q[i].dat)) begin
                n_bad++; $display("FAIL io_err io[%0d] got we=%0b adr=%h dat=%h want we=%0b adr=%h dat=%h", i, obs_q[i].we, obs_q[i].adr, obs_q[i].dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
            end
        end
        n_cmp++;
        if (obs_q.size() < 3 || obs_q[1].dat !== 16'h0000 || obs_q[2].dat !== 16'h0001) begin
            n_bad++; $display("FAIL io_err_ld_zero got %0d accesses want st 6=0000 then st 7=0001", obs_q.size());
        end
        io_err_adr = -1;
    endtask

    task automatic test_mem_error();
        for (int kind = 1; kind <= 2; kind++) begin
            foreach (prog[i]) prog[i] = 16'hF000;
            prog[0] = enc8(8, 1, 8'h7F);
            prog[1] = enc(10, 2, 1, 15);
            prog[2] = enc(1, 3, 2, 1);
            prog[3] = enc(14, 3, 0, 1);
            prog[4] = enc(14, 2, 0, 2);
            prog[5] = enc8(9, 1, 8'h12);
            prog[6] = enc(14, 1, 0, 3);
            mem_wait = 0; io_wait = 0;
            mem_fault = kind;
            run_prog();
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin
                n_bad++; $display("FAIL mem_fault%0d io_count got %0d want %0d", kind, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i].we !== exp_q[i].we || obs_q[i].adr != exp_q[i].adr || obs_q[i].dat !== exp_q[i].dat) begin
                    n_bad++; $display("FAIL mem_fault%0d io[%0d] got adr=%h dat=%h want adr=%h dat=%h", kind, i, obs_q[i].adr, obs_q[i].dat, exp_q[i].adr, exp_q[i].dat);
                end
            end
            n_cmp++;
            if (fill_q.size() != 2 || fill_q[0] != 0 || fill_q[1] != 0) begin
                n_bad++; $display("FAIL mem_fault%0d refetch got %0d bursts want 2 at adr 0", kind, fill_q.size());
            end
        end
    endtask

    task automatic test_random();
        int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13};
        int idx, op, d;
        for (int it = 0; it < 6; it++) begin
            foreach (prog[i]) prog[i] = 16'hF000;
            idx = 0;
            for (int r = 1; r < 16; r++) prog[idx++] = enc8(8, r, int'($urandom_range(0, 255)));
            for (int k = 0; k < 24; k++) begin
                op = ops[$urandom_range(0, 12)];
                d = int'($urandom_range(0, 15));
                if (op == 8 || op == 9) prog[idx++] = enc8(op, d, int'($urandom_range(0, 255)));
                else if (op == 11) prog[idx++] = enc8(op, d, int'($urandom_range(0, 3)));
                else if (op == 13) prog[idx++] = enc(op, d, 0, int'($urandom_range(0, 15)));
                else prog[idx++] = enc(op, d, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            for (int r = 0; r < 16; r++) prog[idx++] = enc(14, r, 0, 0);
            mem_wait = int'($urandom_range(0, 2)); io_wait = int'($urandom_range(0, 3)); io_err_adr = -1;
            run_prog();
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d io_count got %0d want %0d", it, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i].we !== exp_q[i].we || obs_q[i].adr != exp_q[i].adr || (exp_q[i].we && obs_q[i].dat !== exp_q[i].dat)) begin
                    n_bad++; $display("FAIL rand%0d io[%0d] got we=%0b adr=%h dat=%h want we=%0b adr=%h dat=%h", it, i, obs_q[i].we, obs_q[i].adr, obs_q[i].dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
                end
            end
            n_cmp++;
            if (viol != 0 || io_viol != 0) begin
                n_bad++; $display("FAIL rand%0d protocol got mem=%0d io=%0d violations want 0", it, viol, io_viol);
            end
        end
    endtask

    initial begin
        bus.mem_sel_i = 4'h0;
        bus.io_sel_i  = 2'b00;
        test_reset();
        test_reset_mid_burst();
        test_program();
        test_io_error();
        test_mem_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
